// File: rtl/systolic_array_controller_pkg.sv
// Shared types and default sizing for the systolic array controller and its consumers.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } ctrl_state_t;

    localparam int N_DEF       = 4;
    localparam int MUL_LEN_DEF = 2;

    // Bits needed to hold step indices 0..3N-3 (one spare code above the last step).
    function automatic int step_width(input int n);
        return $clog2(3 * n - 1);
    endfunction

endpackage

// File: rtl/systolic_array_controller_skew_gen.sv
// Diagonal skew decode: which input rows and which output columns are live at step s.
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = step_width(N_DEF)
) (
    input  logic [SW-1:0] step,
    output logic [N-1:0]  in_en_raw,
    output logic [N-1:0]  col_win_raw
);

    // Row r sees data on steps r..r+N-1; column c drains on steps N-1+c..2N-2+c.
    always_comb begin
        in_en_raw   = '0;
        col_win_raw = '0;
        for (int i = 0; i < N; i++) begin
            in_en_raw[i]   = (int'(step) >= i) && (int'(step) - i <= N - 1);
            col_win_raw[i] = (int'(step) >= N - 1 + i) && (int'(step) - (N - 1) - i <= N - 1);
        end
    end

endmodule

// File: rtl/systolic_array_controller.sv
// Job sequencer for an N x N weight-stationary systolic array: weight preload,
// skewed input streaming, partial-sum drain and per-column valid flags.
module systolic_array_controller
    import systolic_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int MUL_LEN = MUL_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         reuse_w,
    output logic         busy,
    output logic         done,
    input  logic         w_row_valid,
    output logic         w_row_ready,
    output logic [N-1:0] w_load_en,
    input  logic         in_row_valid,
    output logic         in_row_ready,
    output logic [N-1:0] in_en,
    output logic         mac_start,
    output logic         mac_count,
    output logic [N-1:0] out_col_valid
);

    localparam int SW = step_width(N);
    localparam int CW = (MUL_LEN > 1) ? $clog2(MUL_LEN) : 1;
    localparam int RW = $clog2(N);

    localparam logic [SW-1:0] STEP_LAST   = SW'(3 * N - 3);
    localparam logic [SW-1:0] STEP_NOSTALL = SW'(N);
    localparam logic [CW-1:0] CYC_LAST    = CW'(MUL_LEN - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(N - 1);

    ctrl_state_t   state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [RW-1:0] row_q, row_d;

    logic          step_active;
    logic [N-1:0]  in_en_raw;
    logic [N-1:0]  col_win_raw;

    // A step in progress always continues; a new step in the fill phase waits for an input row.
    assign step_active = (cyc_q != '0) || (step_q >= STEP_NOSTALL) || in_row_valid;

    systolic_skew_gen #(
        .N  (N),
        .SW (SW)
    ) u_skew (
        .step        (step_q),
        .in_en_raw   (in_en_raw),
        .col_win_raw (col_win_raw)
    );

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cyc_d   = cyc_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                step_d = '0;
                cyc_d  = '0;
                row_d  = '0;
                if (start) begin
                    state_d = reuse_w ? STREAM : LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_row_valid) begin
                    if (row_q == ROW_LAST) begin
                        state_d = STREAM;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            STREAM: begin
                if (step_active) begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_d = '0;
                        if (step_q == STEP_LAST) begin
                            state_d = DONE;
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any job immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            cyc_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cyc_q   <= cyc_d;
            row_q   <= row_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign w_row_ready   = (state_q == LOAD_W);
    assign w_load_en     = (w_row_ready && w_row_valid) ? (N'(1) << row_q) : '0;
    assign in_row_ready  = (state_q == STREAM) && (cyc_q == '0) && (step_q < STEP_NOSTALL);
    assign mac_start     = (state_q == STREAM) && (cyc_q == '0) && step_active;
    assign mac_count     = (state_q == STREAM) && (cyc_q != CYC_LAST);
    assign in_en         = ((state_q == STREAM) && step_active) ? in_en_raw : '0;
    assign out_col_valid = ((state_q == STREAM) && step_active && (cyc_q == CYC_LAST)) ? col_win_raw : '0;

endmodule

// File: tb/tb_systolic_array_controller.sv
// Directed bench: each job is expanded into a cycle-by-cycle expected trace from the
// step schedule (load beats, optional stall cycles, MUL_LEN cycles per step, done).
module tb_systolic_array_controller;

    localparam int N  = 4;
    localparam int ML = 2;
    localparam int T  = 3 * N - 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         reuse_w;
    logic         busy;
    logic         done;
    logic         w_row_valid;
    logic         w_row_ready;
    logic [N-1:0] w_load_en;
    logic         in_row_valid;
    logic         in_row_ready;
    logic [N-1:0] in_en;
    logic         mac_start;
    logic         mac_count;
    logic [N-1:0] out_col_valid;

    systolic_array_controller #(.N(N), .MUL_LEN(ML)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .reuse_w       (reuse_w),
        .busy          (busy),
        .done          (done),
        .w_row_valid   (w_row_valid),
        .w_row_ready   (w_row_ready),
        .w_load_en     (w_load_en),
        .in_row_valid  (in_row_valid),
        .in_row_ready  (in_row_ready),
        .in_en         (in_en),
        .mac_start     (mac_start),
        .mac_count     (mac_count),
        .out_col_valid (out_col_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic st, rw, wv, iv;
        logic busy, done, wr, ir, ms, mc;
        logic [N-1:0] wl, ien, ocv;
    } rec_t;

    rec_t trace[$];
    rec_t exp_r;
    logic exp_on = 1'b0;

    int tests = 0;
    int fails = 0;
    int done_idx;
    int ms_cnt;
    logic [N-1:0] ien_at [0:63];
    logic [N-1:0] ocv_at [0:63];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, a, e);
        end
    endtask

    // Every cycle: DUT outputs against the expected trace entry.
    always @(negedge clk) begin
        if (exp_on) begin
            chk("busy",          32'(busy),          32'(exp_r.busy));
            chk("done",          32'(done),          32'(exp_r.done));
            chk("w_row_ready",   32'(w_row_ready),   32'(exp_r.wr));
            chk("w_load_en",     32'(w_load_en),     32'(exp_r.wl));
            chk("in_row_ready",  32'(in_row_ready),  32'(exp_r.ir));
            chk("in_en",         32'(in_en),         32'(exp_r.ien));
            chk("mac_start",     32'(mac_start),     32'(exp_r.ms));
            chk("mac_count",     32'(mac_count),     32'(exp_r.mc));
            chk("out_col_valid", 32'(out_col_valid), 32'(exp_r.ocv));
        end
    end

    // Expand one job into its expected per-cycle trace. Entry 0 is the accepting IDLE cycle.
    task automatic build(input bit reuse, input int wgap_at, input int wgap_len,
                         input int sgap_at, input int sgap_len, input bit hold);
        rec_t r;
        trace.delete();
        r = '0; r.st = 1'b1; r.rw = reuse;
        trace.push_back(r);
        if (!reuse) begin
            for (int k = 0; k < N; k++) begin
                if (k == wgap_at) begin
                    for (int g = 0; g < wgap_len; g++) begin
                        r = '0; r.busy = 1'b1; r.wr = 1'b1;
                        trace.push_back(r);
                    end
                end
                r = '0; r.busy = 1'b1; r.wr = 1'b1; r.wv = 1'b1; r.wl[k] = 1'b1;
                trace.push_back(r);
            end
        end
        for (int s = 0; s < T; s++) begin
            if (s == sgap_at && s < N) begin
                for (int g = 0; g < sgap_len; g++) begin
                    r = '0; r.busy = 1'b1; r.wv = 1'b1; r.ir = 1'b1; r.mc = (ML > 1);
                    trace.push_back(r);
                end
            end
            for (int c = 0; c < ML; c++) begin
                r = '0; r.busy = 1'b1; r.wv = 1'b1; r.iv = 1'b1;
                r.ir = (c == 0) && (s < N);
                r.ms = (c == 0);
                r.mc = (c < ML - 1);
                for (int q = 0; q < N; q++) begin
                    r.ien[q] = (s - q >= 0) && (s - q <= N - 1);
                    if (c == ML - 1)
                        r.ocv[q] = (s - (N - 1) - q >= 0) && (s - (N - 1) - q <= N - 1);
                end
                trace.push_back(r);
            end
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1;
        trace.push_back(r);
        if (hold) begin
            for (int i = 1; i < trace.size(); i++) begin
                trace[i].st = 1'b1;
                trace[i].rw = (i % 2 == 1);
            end
        end
        r = '0;
        trace.push_back(r);
        trace.push_back(r);
    endtask

    // Drive entries [0, stop) of the trace, one per clock; entered just after a rising edge.
    task automatic run(input int stop);
        done_idx = -1;
        ms_cnt   = 0;
        for (int i = 0; i < stop && i < trace.size(); i++) begin
            start        = trace[i].st;
            reuse_w      = trace[i].rw;
            w_row_valid  = trace[i].wv;
            in_row_valid = trace[i].iv;
            exp_r        = trace[i];
            exp_on       = 1'b1;
            @(negedge clk);
            if (done === 1'b1 && done_idx < 0) done_idx = i;
            if (mac_start === 1'b1) ms_cnt++;
            if (i < 64) begin
                ien_at[i] = in_en;
                ocv_at[i] = out_col_valid;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; reuse_w = 1'b0; w_row_valid = 1'b0; in_row_valid = 1'b0;
        exp_r = '0; exp_on = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        // Full job with weight load.
        build(1'b0, -1, 0, -1, 0, 1'b0);
        run(1000);
        chk("done_cycle_load", 32'(done_idx), 32'd25);
        chk("mac_pulses_load", 32'(ms_cnt), 32'd10);

        // Weight reuse; skew literals at s=3,6,9 (second cycle of each step).
        build(1'b1, -1, 0, -1, 0, 1'b0);
        run(1000);
        chk("done_cycle_reuse", 32'(done_idx), 32'd21);
        chk("mac_pulses_reuse", 32'(ms_cnt), 32'd10);
        chk("in_en_s3",  32'(ien_at[8]),  32'b1111);
        chk("ocv_s3",    32'(ocv_at[8]),  32'b0001);
        chk("in_en_s6",  32'(ien_at[14]), 32'b1000);
        chk("ocv_s6",    32'(ocv_at[14]), 32'b1111);
        chk("in_en_s9",  32'(ien_at[20]), 32'b0000);
        chk("ocv_s9",    32'(ocv_at[20]), 32'b1000);

        // Input stall of 3 cycles at s=2.
        build(1'b1, -1, 0, 2, 3, 1'b0);
        run(1000);
        chk("done_cycle_stall", 32'(done_idx), 32'd24);
        chk("mac_pulses_stall", 32'(ms_cnt), 32'd10);

        // start held high through the job and the DONE cycle; one weight-beat gap.
        build(1'b0, 2, 1, -1, 0, 1'b1);
        run(1000);
        chk("done_cycle_held", 32'(done_idx), 32'd26);

        // Reset at s=5 (cycle 0 of that step), then a normal job.
        build(1'b1, -1, 0, -1, 0, 1'b0);
        run(11);
        exp_r = '0;
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        build(1'b0, -1, 0, -1, 0, 1'b0);
        run(1000);
        chk("done_cycle_after_rst", 32'(done_idx), 32'd25);

        exp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
